writeback_cycle: RTL and testbench



---
 rtl/rv_pkg.sv | 21 ++
 rtl/load_extender.sv | 26 ++
 rtl/writeback_cycle.sv | 81 ++++++++
 tb/tb_writeback_cycle.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// rv_pkg: shared RV32I write-back types, load funct3 codes and datapath width.
package rv_pkg;
   localparam int XLEN = 32;
   localparam logic [2:0] LB  = 3'b000;
   localparam logic [2:0] LH  = 3'b001;
   localparam logic [2:0] LW  = 3'b010;
   localparam logic [2:0] LBU = 3'b100;
   localparam logic [2:0] LHU = 3'b101;
   typedef enum logic [1:0] {WB_ALU, WB_LOAD, WB_LINK} wbSelT;
   typedef struct packed {
      logic valid;
      logic regWrite;
      logic memRead;
      logic jtype;
      logic [4:0] rd;
      logic [XLEN-1:0] aluOut;
      logic [XLEN-1:0] pcPlus4;
      logic [XLEN-1:0] dataMemOut;
      logic [2:0] funct3;
   } memWbT;
endpackage

// File: rtl/load_extender.sv
// load_extender: byte/halfword lane select with sign/zero extension and load fault detection.
module load_extender
   import rv_pkg::*;
(
   input  logic [XLEN-1:0] word,
   input  logic [1:0]      addr,
   input  logic [2:0]      funct3,
   output logic [XLEN-1:0] data,
   output logic            fault
);
   logic [7:0] lane8;
   logic [15:0] lane16;
   logic illegal;
   logic misaligned;
   always_comb begin
      lane8 = 8'(word >> {addr, 3'b000});
      lane16 = addr[1] ? word[31:16] : word[15:0];
      data = funct3 == LB  ? {{24{lane8[7]}}, lane8} :
             funct3 == LBU ? {24'b0, lane8} :
             funct3 == LH  ? {{16{lane16[15]}}, lane16} :
             funct3 == LHU ? {16'b0, lane16} : word;
      illegal = funct3 inside {3'b011, 3'b110, 3'b111};
      misaligned = (funct3[1:0] == 2'b01 && addr[0]) || (funct3 == LW && addr != 2'b00);
      fault = illegal | misaligned;
   end
endmodule

// File: rtl/writeback_cycle.sv
// writeback_cycle: MEM/WB register, load extension, register-file write and forwarding bus.
// Define WB_RETIRE_COUNT_EN to build the retired-instruction counter.
module writeback_cycle
   import rv_pkg::memWbT, rv_pkg::wbSelT, rv_pkg::WB_ALU, rv_pkg::WB_LOAD, rv_pkg::WB_LINK;
#(
   parameter int XLEN = 32,
   parameter int CNT_W = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             Stall,
   input  logic             Flush,
   input  logic             ValidW,
   input  logic             RegWriteW,
   input  logic             MemReadW,
   input  logic             JtypeW,
   input  logic [XLEN-1:0]  DataMemOutW,
   input  logic [XLEN-1:0]  ALUOutW,
   input  logic [XLEN-1:0]  PCPlus4W,
   input  logic [5:0]       ALUSelectW,
   input  logic [4:0]       WriteAddressW,
   output logic             RegFileWE,
   output logic [4:0]       RegFileWA,
   output logic [XLEN-1:0]  RegFileWD,
   output logic             FwdValid,
   output logic [4:0]       FwdAddr,
   output logic [XLEN-1:0]  FwdData,
   output logic             LoadFault,
   output logic [CNT_W-1:0] RetireCount
);
   memWbT mw;
   wbSelT wbSel;
   logic [XLEN-1:0] loadData;
   logic extFault;
   logic fault;
   logic [2:0] unusedSel;
   assign unusedSel = ALUSelectW[5:3];
   always_ff @(posedge clk or posedge reset) begin
      if (reset) mw <= '0;
      else if (Flush) mw <= '0;
      else if (!Stall) mw <= {ValidW, RegWriteW, MemReadW, JtypeW, WriteAddressW, ALUOutW, PCPlus4W, DataMemOutW, ALUSelectW[2:0]};
   end
   load_extender regExt (
      .word(mw.dataMemOut),
      .addr(mw.aluOut[1:0]),
      .funct3(mw.funct3),
      .data(loadData),
      .fault(extFault)
   );
   // Only loads can fault; funct3 bits of other instructions are ALU selects.
   always_comb begin
      fault = mw.memRead & extFault;
      wbSel = mw.jtype ? WB_LINK : mw.memRead ? WB_LOAD : WB_ALU;
      RegFileWD = wbSel == WB_LINK ? mw.pcPlus4 : wbSel == WB_LOAD ? loadData : mw.aluOut;
      RegFileWE = mw.valid & mw.regWrite & (mw.rd != 5'd0) & ~fault;
      RegFileWA = mw.rd;
      LoadFault = mw.valid & fault;
   end
   assign FwdValid = RegFileWE;
   assign FwdAddr = RegFileWA;
   assign FwdData = RegFileWD;
`ifdef WB_RETIRE_COUNT_EN
   logic [XLEN-1:0] unusedInData;
   logic inFault;
   logic [CNT_W-1:0] retireCnt;
   load_extender inExt (
      .word(DataMemOutW),
      .addr(ALUOutW[1:0]),
      .funct3(ALUSelectW[2:0]),
      .data(unusedInData),
      .fault(inFault)
   );
   always_ff @(posedge clk or posedge reset) begin
      if (reset) retireCnt <= '0;
      else if (ValidW & ~Stall & ~Flush & ~(MemReadW & inFault)) retireCnt <= retireCnt + 1'b1;
   end
   assign RetireCount = retireCnt;
`else
   assign RetireCount = '0;
`endif
endmodule

// File: tb/tb_writeback_cycle.sv
// tb_writeback_cycle: directed and random checks of writeback_cycle against a behavioural model.
module tb_writeback_cycle;
   typedef struct {
      bit valid, regWrite, memRead, jtype;
      bit [4:0] rd;
      bit [31:0] alu, pc, data;
      bit [2:0] f3;
   } instT;
   localparam int CW = 8;
`ifdef WB_RETIRE_COUNT_EN
   localparam bit CNT_ON = 1'b1;
`else
   localparam bit CNT_ON = 1'b0;
`endif
   logic clk = 1'b0;
   logic reset, Stall, Flush, ValidW, RegWriteW, MemReadW, JtypeW;
   logic [31:0] DataMemOutW, ALUOutW, PCPlus4W;
   logic [5:0] ALUSelectW;
   logic [4:0] WriteAddressW;
   logic RegFileWE, FwdValid, LoadFault;
   logic [4:0] RegFileWA, FwdAddr;
   logic [31:0] RegFileWD, FwdData;
   logic [CW-1:0] RetireCount;
   int checks = 0;
   int errors = 0;
   instT held, cur, bubble;
   int unsigned modelCnt;

   writeback_cycle #(.XLEN(32), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .Stall(Stall), .Flush(Flush), .ValidW(ValidW),
      .RegWriteW(RegWriteW), .MemReadW(MemReadW), .JtypeW(JtypeW),
      .DataMemOutW(DataMemOutW), .ALUOutW(ALUOutW), .PCPlus4W(PCPlus4W),
      .ALUSelectW(ALUSelectW), .WriteAddressW(WriteAddressW),
      .RegFileWE(RegFileWE), .RegFileWA(RegFileWA), .RegFileWD(RegFileWD),
      .FwdValid(FwdValid), .FwdAddr(FwdAddr), .FwdData(FwdData),
      .LoadFault(LoadFault), .RetireCount(RetireCount)
   );

   always #5 clk = ~clk;

   task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit isFault(instT i);
      int unsigned a = i.alu % 4;
      bit bad = (i.f3 == 3 || i.f3 == 6 || i.f3 == 7) ||
                ((i.f3 == 1 || i.f3 == 5) && a % 2 == 1) || (i.f3 == 2 && a != 0);
      return i.memRead && bad;
   endfunction

   function automatic bit [31:0] loadVal(instT i);
      int unsigned a = i.alu % 4;
      bit [31:0] b = (i.data >> (8 * a)) & 32'hFF;
      bit [31:0] h = (i.data >> (16 * (a / 2))) & 32'hFFFF;
      case (i.f3)
         0: return b >= 128 ? b + 32'hFFFFFF00 : b;
         4: return b;
         1: return h >= 32768 ? h + 32'hFFFF0000 : h;
         5: return h;
         default: return i.data;
      endcase
   endfunction

   task automatic compareAll(string tag);
      bit f = isFault(held);
      bit [31:0] wd = held.jtype ? held.pc : held.memRead ? loadVal(held) : held.alu;
      bit we = held.valid && held.regWrite && held.rd != 0 && !f;
      bit [CW-1:0] cnt = CNT_ON ? CW'(modelCnt) : '0;
      check({tag, ".we"}, RegFileWE, we);
      check({tag, ".wa"}, RegFileWA, held.rd);
      check({tag, ".wd"}, RegFileWD, wd);
      check({tag, ".fwdValid"}, FwdValid, we);
      check({tag, ".fwdAddr"}, FwdAddr, held.rd);
      check({tag, ".fwdData"}, FwdData, wd);
      check({tag, ".loadFault"}, LoadFault, held.valid && f);
      check({tag, ".retire"}, RetireCount, cnt);
   endtask

   function automatic instT mk(bit v, bit rw, bit mr, bit j, bit [4:0] rd,
                               bit [31:0] alu, bit [31:0] pc, bit [31:0] data, bit [2:0] f3);
      instT i;
      i.valid = v; i.regWrite = rw; i.memRead = mr; i.jtype = j; i.rd = rd;
      i.alu = alu; i.pc = pc; i.data = data; i.f3 = f3;
      return i;
   endfunction

   task automatic drive(instT i, bit st, bit fl);
      cur = i;
      ValidW = i.valid; RegWriteW = i.regWrite; MemReadW = i.memRead; JtypeW = i.jtype;
      WriteAddressW = i.rd; ALUOutW = i.alu; PCPlus4W = i.pc; DataMemOutW = i.data;
      ALUSelectW = {3'($urandom), i.f3};
      Stall = st; Flush = fl;
   endtask

   task automatic step(string tag);
      @(posedge clk);
      if (!Stall && !Flush && cur.valid && !isFault(cur)) modelCnt = (modelCnt + 1) % (1 << CW);
      if (Flush) held = bubble;
      else if (!Stall) held = cur;
      #1 compareAll(tag);
   endtask

   initial begin
      instT a, b;
      bubble = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
      held = bubble;
      modelCnt = 0;
      reset = 1'b1;
      drive(bubble, 0, 0);
      #3 compareAll("reset");
      @(negedge clk) reset = 1'b0;

      drive(mk(1, 1, 1, 0, 5, 32'h1003, 32'h100, 32'h80FF7F01, 3'b000), 0, 0);
      step("lb");
      check("lbConst", RegFileWD, 32'hFFFFFF80);
      drive(mk(1, 1, 1, 0, 5, 32'h1003, 32'h100, 32'h80FF7F01, 3'b100), 0, 0);
      step("lbu");
      check("lbuConst", RegFileWD, 32'h00000080);
      drive(mk(1, 1, 1, 0, 6, 32'h1002, 32'h104, 32'h80011234, 3'b001), 0, 0);
      step("lh");
      check("lhConst", RegFileWD, 32'hFFFF8001);
      drive(mk(1, 1, 1, 0, 7, 32'h1001, 32'h108, 32'h12345678, 3'b010), 0, 0);
      step("lwMisaligned");
      check("lwFaultConst", LoadFault, 1'b1);
      drive(mk(1, 1, 0, 0, 1, 32'hDEAD, 32'h44, 32'h0, 3'b000), 0, 0);
      cur.jtype = 1'b1; JtypeW = 1'b1;
      step("jal");
      check("jalConst", RegFileWD, 32'h44);
      check("faultOneCycle", LoadFault, 1'b0);
      drive(mk(1, 1, 0, 0, 0, 32'h55, 32'h48, 32'h0, 3'b000), 0, 0);
      step("aluRd0");

      a = mk(1, 1, 0, 0, 9, 32'h1111, 32'h200, 32'h0, 3'b000);
      b = mk(1, 1, 0, 0, 10, 32'h2222, 32'h204, 32'h0, 3'b000);
      drive(a, 0, 0);
      step("stallA");
      for (int k = 0; k < 3; k++) begin
         drive(b, 1, 0);
         step("stallHold");
         check("stallHoldConst", RegFileWD, 32'h1111);
      end
      drive(b, 0, 0);
      step("stallRelease");
      check("releaseConst", RegFileWD, 32'h2222);
      drive(a, 1, 1);
      step("flushStall");

      drive(a, 0, 0);
      step("preReset");
      drive(b, 1, 0);
      #2 reset = 1'b1;
      #1 held = bubble;
      modelCnt = 0;
      compareAll("asyncReset");
      @(negedge clk) reset = 1'b0;

      for (int k = 0; k < 300 && modelCnt != (1 << CW) - 2; k++) begin
         drive(mk(1, 1, 0, 0, 3, $urandom, $urandom, $urandom, 3'($urandom)), 0, 0);
         step("preload");
      end
      for (int k = 0; k < 3; k++) begin
         drive(mk(1, 1, 0, 0, 4, $urandom, $urandom, $urandom, 3'($urandom)), 0, 0);
         step("wrap");
      end

      for (int k = 0; k < 500; k++) begin
         instT r = mk($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                      $urandom_range(0, 6) == 0, 5'($urandom), $urandom, $urandom, $urandom, 3'($urandom));
         drive(r, $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0);
         step("random");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
